// File: rtl/phase_pkg.sv
// Shared constants, FSM state type and phase helpers for the five-phase clock bus receiver.
// Purely declarative; no latency and no backpressure.
// Consumers: phase_onehot_dec, phase_stage_ctrl.
package phase_pkg;
    localparam int NUM_PHASES = 5;

    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_DECODE = 3'd1;
    localparam logic [2:0] PH_EXEC   = 3'd2;
    localparam logic [2:0] PH_MEM    = 3'd3;
    localparam logic [2:0] PH_WB     = 3'd4;
    localparam logic [2:0] PH_NONE   = 3'd7;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    function automatic logic [2:0] next_phase(input logic [2:0] idx);
        return (idx == PH_WB) ? PH_FETCH : idx + 3'd1;
    endfunction

    function automatic logic [NUM_PHASES-1:0] ph_onehot(input logic [2:0] idx);
        logic [NUM_PHASES-1:0] one;
        one = 5'b00001;
        return one << idx;
    endfunction
endpackage

// File: rtl/phase_onehot_dec.sv
// Decodes the five phase strobes into {valid, index}; valid only when exactly one bit is set.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure function of the strobes.
module phase_onehot_dec
    import phase_pkg::*;
(
    input  logic [NUM_PHASES-1:0] phases,
    output logic                  dec_vld,
    output logic [2:0]            dec_idx
);
    always_comb begin
        dec_vld = 1'b1;
        dec_idx = PH_NONE;
        case (phases)
            5'b00001: dec_idx = PH_FETCH;
            5'b00010: dec_idx = PH_DECODE;
            5'b00100: dec_idx = PH_EXEC;
            5'b01000: dec_idx = PH_MEM;
            5'b10000: dec_idx = PH_WB;
            default:  dec_vld = 1'b0;
        endcase
    end
endmodule

// File: rtl/phase_stage_ctrl.sv
// Phase-bus receiver: checks 0->1->2->3->4->0 order, drives stage enables, counts cycles and faults.
// Latency: one cycle, every output is registered. Optional fault counter: PHASE_ERRCNT_EN.
// Backpressure: stall only masks stage_en; sequence tracking and counters keep running.
module phase_stage_ctrl
    import phase_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_PHASES-1:0] Phases,
    input  logic                  stall,
    output logic [NUM_PHASES-1:0] stage_en,
    output logic [2:0]            phase_idx,
    output logic                  in_sync,
    output logic                  cyc_done,
    output logic [CNT_W-1:0]      cyc_count,
    output logic                  phase_err,
    output logic                  err_sticky,
    output logic [7:0]            err_count
);
    state_t                  state_q, state_d;
    logic [NUM_PHASES-1:0]   stage_en_q, stage_en_d;
    logic [2:0]              phase_idx_q, phase_idx_d;
    logic                    cyc_done_q, cyc_done_d;
    logic [CNT_W-1:0]        cyc_count_q, cyc_count_d;
    logic                    phase_err_q, phase_err_d;
    logic                    err_sticky_q, err_sticky_d;
    logic                    dec_vld;
    logic [2:0]              dec_idx;
    logic                    accept;
    logic                    fault_entry;

    phase_onehot_dec u_dec (
        .phases  (Phases),
        .dec_vld (dec_vld),
        .dec_idx (dec_idx)
    );

    // In RUN phase_idx_q always holds the last accepted phase, so it also encodes the expected one.
    always_comb begin
        accept      = 1'b0;
        fault_entry = 1'b0;
        case (state_q)
            SYNC: accept = dec_vld && (dec_idx == PH_FETCH);
            RUN: begin
                accept      = dec_vld && (dec_idx == next_phase(phase_idx_q));
                fault_entry = !accept;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= SYNC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (accept) state_d = RUN;
            RUN:     if (fault_entry) state_d = FAULT;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        stage_en_d   = '0;
        phase_idx_d  = phase_idx_q;
        cyc_done_d   = 1'b0;
        cyc_count_d  = cyc_count_q;
        phase_err_d  = fault_entry;
        err_sticky_d = err_sticky_q | fault_entry;
        if (accept) begin
            phase_idx_d = dec_idx;
            if (!stall) stage_en_d = ph_onehot(dec_idx);
            // Phase0 accepted in RUN can only follow Phase4; the resync Phase0 from SYNC never counts.
            if (state_q == RUN && dec_idx == PH_FETCH) begin
                cyc_done_d  = 1'b1;
                cyc_count_d = cyc_count_q + 1'b1;
            end
        end else if (fault_entry || state_q == FAULT) begin
            phase_idx_d = PH_NONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_en_q   <= '0;
            phase_idx_q  <= PH_NONE;
            cyc_done_q   <= 1'b0;
            cyc_count_q  <= '0;
            phase_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            stage_en_q   <= stage_en_d;
            phase_idx_q  <= phase_idx_d;
            cyc_done_q   <= cyc_done_d;
            cyc_count_q  <= cyc_count_d;
            phase_err_q  <= phase_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef PHASE_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (fault_entry && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) err_count_q <= 8'h00;
        else     err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

    assign stage_en   = stage_en_q;
    assign phase_idx  = phase_idx_q;
    assign in_sync    = (state_q == RUN);
    assign cyc_done   = cyc_done_q;
    assign cyc_count  = cyc_count_q;
    assign phase_err  = phase_err_q;
    assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_phase_stage_ctrl.sv
// Bench for phase_stage_ctrl: directed scenarios then random strobes, scored against a behavioural model.
module tb_phase_stage_ctrl;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [4:0]       Phases = 5'b0;
    logic             stall = 1'b0;
    logic [4:0]       stage_en;
    logic [2:0]       phase_idx;
    logic             in_sync;
    logic             cyc_done;
    logic [CNT_W-1:0] cyc_count;
    logic             phase_err;
    logic             err_sticky;
    logic [7:0]       err_count;

    phase_stage_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Phases     (Phases),
        .stall      (stall),
        .stage_en   (stage_en),
        .phase_idx  (phase_idx),
        .in_sync    (in_sync),
        .cyc_done   (cyc_done),
        .cyc_count  (cyc_count),
        .phase_err  (phase_err),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]       stage_en;
        logic [2:0]       phase_idx;
        logic             in_sync;
        logic             cyc_done;
        logic [CNT_W-1:0] cyc_count;
        logic             phase_err;
        logic             err_sticky;
        logic [7:0]       err_count;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0=waiting for sync, 1=running, 2=fault cycle; last = last accepted phase, 7 if none.
    int   m_mode  = 0;
    int   m_last  = 7;
    int   m_cyc   = 0;
    int   m_errs  = 0;
    bit   m_sticky = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [4:0] ph, input bit st);
        exp_t e;
        int   nxt;
        @(negedge CLK);
        RST    = rst;
        Phases = ph;
        stall  = st;
        e = '0;
        if (rst) begin
            m_mode = 0; m_last = 7; m_cyc = 0; m_errs = 0; m_sticky = 1'b0;
        end else begin
            case (m_mode)
                0: if (ph == 5'b00001) begin
                    m_mode = 1;
                    m_last = 0;
                    e.stage_en = st ? 5'b0 : 5'b00001;
                end
                1: begin
                    nxt = (m_last + 1) % 5;
                    if (ph == (5'b00001 << nxt)) begin
                        m_last = nxt;
                        e.stage_en = st ? 5'b0 : ph;
                        if (nxt == 0) begin
                            m_cyc = (m_cyc + 1) % (1 << CNT_W);
                            e.cyc_done = 1'b1;
                        end
                    end else begin
                        m_mode = 2;
                        m_last = 7;
                        e.phase_err = 1'b1;
                        m_sticky = 1'b1;
                        if (m_errs < 255) m_errs++;
                    end
                end
                default: m_mode = 0;
            endcase
        end
        e.phase_idx  = 3'(m_last);
        e.in_sync    = (m_mode == 1);
        e.cyc_count  = CNT_W'(m_cyc);
        e.err_sticky = m_sticky;
`ifdef PHASE_ERRCNT_EN
        e.err_count  = 8'(m_errs);
`else
        e.err_count  = 8'h00;
`endif
        sb_q.push_back(e);
    endtask

    task automatic legal_loops(input int n);
        for (int l = 0; l < n; l++)
            for (int p = 0; p < 5; p++) step(1'b0, 5'b00001 << p, 1'b0);
    endtask

    // Monitor: every output is registered, so each stimulus cycle yields one expected record.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stage_en",   int'(stage_en),   int'(e.stage_en));
                check("phase_idx",  int'(phase_idx),  int'(e.phase_idx));
                check("in_sync",    int'(in_sync),    int'(e.in_sync));
                check("cyc_done",   int'(cyc_done),   int'(e.cyc_done));
                check("cyc_count",  int'(cyc_count),  int'(e.cyc_count));
                check("phase_err",  int'(phase_err),  int'(e.phase_err));
                check("err_sticky", int'(err_sticky), int'(e.err_sticky));
                check("err_count",  int'(err_count),  int'(e.err_count));
            end
        end
    end

    initial begin
        int  g;
        int  budget;
        logic [4:0] ph;

        step(1'b1, 5'b0, 1'b0);
        step(1'b1, 5'b0, 1'b0);
        legal_loops(3);
        step(1'b0, 5'b00001, 1'b0);

        // Out-of-sync strobe is ignored, then Phase0 locks.
        step(1'b1, 5'b0, 1'b0);
        step(1'b0, 5'b00100, 1'b0);
        step(1'b0, 5'b00001, 1'b0);

        // Skip from Phase1 to Phase3; a Phase0 during the fault cycle is dropped.
        step(1'b0, 5'b00010, 1'b0);
        step(1'b0, 5'b01000, 1'b0);
        step(1'b0, 5'b00001, 1'b0);
        step(1'b0, 5'b00001, 1'b0);

        // Two-hot and all-zero strobes.
        step(1'b0, 5'b00010, 1'b0);
        step(1'b0, 5'b00110, 1'b0);
        step(1'b0, 5'b00000, 1'b0);
        step(1'b0, 5'b00001, 1'b0);
        step(1'b0, 5'b00010, 1'b0);
        step(1'b0, 5'b00000, 1'b0);
        step(1'b0, 5'b00000, 1'b0);

        // Stall across Phase2/3 masks enables only.
        step(1'b0, 5'b00001, 1'b0);
        step(1'b0, 5'b00010, 1'b0);
        step(1'b0, 5'b00100, 1'b1);
        step(1'b0, 5'b01000, 1'b1);
        step(1'b0, 5'b10000, 1'b0);
        step(1'b0, 5'b00001, 1'b0);

        // Counter wrap, then reset in the middle of Phase3.
        step(1'b1, 5'b0, 1'b0);
        legal_loops(17);
        step(1'b0, 5'b00001, 1'b0);
        step(1'b0, 5'b00010, 1'b0);
        step(1'b0, 5'b00100, 1'b0);
        step(1'b1, 5'b01000, 1'b0);
        step(1'b0, 5'b00000, 1'b0);

        g = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 88) ph = 5'b00001 << g;
            else                            ph = 5'($urandom);
            g = (g + 1) % 5;
            step($urandom_range(0, 299) == 0, ph, $urandom_range(0, 3) == 0);
        end
        step(1'b0, 5'b00000, 1'b0);

        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge CLK);
            budget++;
        end
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
